// File: rtl/mem_wb_bridge.sv
// mem_wb_bridge: native valid/ready memory requests to classic or pipelined Wishbone, optional split data port and timeout
module mem_wb_bridge #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int PIPELINED      = 0,
    parameter int SECOND_PORT    = 0,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                    clk_core,
    input  logic                    rst_core,
    input  logic                    mem_valid,
    input  logic                    mem_instr,
    input  logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH/8-1:0] mem_wstrb,
    output logic                    mem_ready,
    output logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    core_cyc,
    output logic                    core_stb,
    output logic                    core_we,
    output logic [DATA_WIDTH/8-1:0] core_sel,
    output logic [ADDR_WIDTH-1:0]   core_addr,
    output logic [DATA_WIDTH-1:0]   core_data_out,
    input  logic [DATA_WIDTH-1:0]   core_data_in,
    input  logic                    core_ack,
    output logic                    data_mem_cyc,
    output logic                    data_mem_stb,
    output logic                    data_mem_we,
    output logic [DATA_WIDTH/8-1:0] data_mem_sel,
    output logic [ADDR_WIDTH-1:0]   data_mem_addr,
    output logic [DATA_WIDTH-1:0]   data_mem_data_out,
    input  logic [DATA_WIDTH-1:0]   data_mem_data_in,
    input  logic                    data_mem_ack,
    output logic                    bus_err,
    output logic [7:0]              timeout_cnt
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    state_t                  r_state;
    logic                    r_port;
    logic                    r_wr;
    logic [31:0]             r_tcnt;
    logic                    r_core_cyc, r_core_stb, r_core_we;
    logic                    r_dm_cyc, r_dm_stb, r_dm_we;
    logic [DATA_WIDTH/8-1:0] r_sel;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_dout;
    logic                    r_ready;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic                    r_err;
    logic [7:0]              r_tocnt;
    logic                    w_new_port;
    logic                    w_new_wr;
    logic                    w_ack;
    logic                    w_tmo;
    logic [DATA_WIDTH-1:0]   w_din;
    assign w_new_port = (SECOND_PORT != 0) && !mem_instr;
    assign w_new_wr   = |mem_wstrb;
    assign w_ack      = r_port ? data_mem_ack : core_ack;
    assign w_din      = r_port ? data_mem_data_in : core_data_in;
    assign w_tmo      = (TIMEOUT_CYCLES != 0) && (r_tcnt == 32'(TIMEOUT_CYCLES - 1));
    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            r_state    <= IDLE;
            r_port     <= 1'b0;
            r_wr       <= 1'b0;
            r_tcnt     <= '0;
            r_core_cyc <= 1'b0;
            r_core_stb <= 1'b0;
            r_core_we  <= 1'b0;
            r_dm_cyc   <= 1'b0;
            r_dm_stb   <= 1'b0;
            r_dm_we    <= 1'b0;
            r_sel      <= '0;
            r_addr     <= '0;
            r_dout     <= '0;
            r_ready    <= 1'b0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
            r_tocnt    <= '0;
        end else begin
            case (r_state)
                IDLE: if (mem_valid) begin
                    r_state    <= REQ;
                    r_port     <= w_new_port;
                    r_wr       <= w_new_wr;
                    r_tcnt     <= '0;
                    r_core_cyc <= !w_new_port;
                    r_core_stb <= !w_new_port;
                    r_core_we  <= !w_new_port && w_new_wr;
                    r_dm_cyc   <= w_new_port;
                    r_dm_stb   <= w_new_port;
                    r_dm_we    <= w_new_port && w_new_wr;
                    r_sel      <= w_new_wr ? mem_wstrb : '1;
                    r_addr     <= mem_addr;
                    r_dout     <= mem_wdata;
                end
                REQ, WAIT: if (w_ack || w_tmo) begin
                    r_state    <= DONE;
                    r_ready    <= 1'b1;
                    r_core_cyc <= 1'b0;
                    r_core_stb <= 1'b0;
                    r_core_we  <= 1'b0;
                    r_dm_cyc   <= 1'b0;
                    r_dm_stb   <= 1'b0;
                    r_dm_we    <= 1'b0;
                    // ack wins over a timeout falling in the same cycle
                    if (w_ack) begin
                        if (!r_wr) r_rdata <= w_din;
                    end else begin
                        r_rdata <= '1;
                        r_err   <= 1'b1;
                        r_tocnt <= r_tocnt + 8'(r_tocnt != 8'hFF);
                    end
                end else begin
                    r_state <= WAIT;
                    r_tcnt  <= r_tcnt + 32'd1;
                    if (PIPELINED != 0) begin
                        r_core_stb <= 1'b0;
                        r_dm_stb   <= 1'b0;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_ready <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign mem_ready         = r_ready;
    assign mem_rdata         = r_rdata;
    assign bus_err           = r_err;
    assign timeout_cnt       = r_tocnt;
    assign core_cyc          = r_core_cyc;
    assign core_stb          = r_core_stb;
    assign core_we           = r_core_we;
    assign core_sel          = r_sel;
    assign core_addr         = r_addr;
    assign core_data_out     = r_dout;
    assign data_mem_cyc      = r_dm_cyc;
    assign data_mem_stb      = r_dm_stb;
    assign data_mem_we       = r_dm_we;
    assign data_mem_sel      = (SECOND_PORT != 0) ? r_sel : '0;
    assign data_mem_addr     = (SECOND_PORT != 0) ? r_addr : '0;
    assign data_mem_data_out = (SECOND_PORT != 0) ? r_dout : '0;
endmodule

// File: tb/tb_mem_wb_bridge.sv
// tb_mem_wb_bridge: table-driven check of a classic/timeout bridge and a pipelined/split-port bridge
module tb_mem_wb_bridge;
    typedef struct {
        int          d;
        logic        instr;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  ws;
        int          dly;
        int          xw;
        logic [31:0] din;
        int          nstb;
        int          ncyc;
        logic        we;
        logic [3:0]  sel;
        int          lat;
        logic [31:0] rdata;
        logic        berr;
        logic [7:0]  tc;
    } vec_t;
    logic        clk = 1'b0;
    logic        rst;
    logic        v[2];
    logic        instr;
    logic [31:0] addr, wdata, din;
    logic [3:0]  wstrb;
    logic        ack, wack;
    int          cur_d;
    logic        cur_p;
    logic        rdy[2], cc[2], cs[2], cw[2], dc[2], ds[2], dw[2], berr[2];
    logic [31:0] rd[2], cadr[2], cdo[2], dadr[2], ddo[2];
    logic [3:0]  csel[2], dsel[2];
    logic [7:0]  tcnt[2];
    logic        cack[2], dack[2];
    logic        cyc_a, stb_a, we_a, cyc_o, rdy_a, berr_a;
    logic [3:0]  sel_a;
    logic [31:0] addr_a, dout_a, rd_a;
    logic [7:0]  tc_a;
    int          total = 0;
    int          bad = 0;
    always #5 clk = ~clk;
    assign cack[0] = (cur_d == 0) && (cur_p ? wack : ack);
    assign dack[0] = (cur_d == 0) && (cur_p ? ack : wack);
    assign cack[1] = (cur_d == 1) && (cur_p ? wack : ack);
    assign dack[1] = (cur_d == 1) && (cur_p ? ack : wack);
    always_comb begin
        cyc_a  = cur_p ? dc[cur_d]   : cc[cur_d];
        stb_a  = cur_p ? ds[cur_d]   : cs[cur_d];
        we_a   = cur_p ? dw[cur_d]   : cw[cur_d];
        sel_a  = cur_p ? dsel[cur_d] : csel[cur_d];
        addr_a = cur_p ? dadr[cur_d] : cadr[cur_d];
        dout_a = cur_p ? ddo[cur_d]  : cdo[cur_d];
        cyc_o  = cur_p ? cc[cur_d]   : dc[cur_d];
        rdy_a  = rdy[cur_d];
        rd_a   = rd[cur_d];
        berr_a = berr[cur_d];
        tc_a   = tcnt[cur_d];
    end
    mem_wb_bridge #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .PIPELINED(0), .SECOND_PORT(0), .TIMEOUT_CYCLES(16)) u0 (
        .clk_core(clk), .rst_core(rst), .mem_valid(v[0]), .mem_instr(instr), .mem_addr(addr),
        .mem_wdata(wdata), .mem_wstrb(wstrb), .mem_ready(rdy[0]), .mem_rdata(rd[0]),
        .core_cyc(cc[0]), .core_stb(cs[0]), .core_we(cw[0]), .core_sel(csel[0]), .core_addr(cadr[0]),
        .core_data_out(cdo[0]), .core_data_in(din), .core_ack(cack[0]),
        .data_mem_cyc(dc[0]), .data_mem_stb(ds[0]), .data_mem_we(dw[0]), .data_mem_sel(dsel[0]),
        .data_mem_addr(dadr[0]), .data_mem_data_out(ddo[0]), .data_mem_data_in(din), .data_mem_ack(dack[0]),
        .bus_err(berr[0]), .timeout_cnt(tcnt[0]));
    mem_wb_bridge #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .PIPELINED(1), .SECOND_PORT(1), .TIMEOUT_CYCLES(0)) u1 (
        .clk_core(clk), .rst_core(rst), .mem_valid(v[1]), .mem_instr(instr), .mem_addr(addr),
        .mem_wdata(wdata), .mem_wstrb(wstrb), .mem_ready(rdy[1]), .mem_rdata(rd[1]),
        .core_cyc(cc[1]), .core_stb(cs[1]), .core_we(cw[1]), .core_sel(csel[1]), .core_addr(cadr[1]),
        .core_data_out(cdo[1]), .core_data_in(din), .core_ack(cack[1]),
        .data_mem_cyc(dc[1]), .data_mem_stb(ds[1]), .data_mem_we(dw[1]), .data_mem_sel(dsel[1]),
        .data_mem_addr(dadr[1]), .data_mem_data_out(ddo[1]), .data_mem_data_in(din), .data_mem_ack(dack[1]),
        .bus_err(berr[1]), .timeout_cnt(tcnt[1]));
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask
    task automatic run_vec(input int k, input vec_t t);
        int   nstb = 0, ncyc = 0, lat = 0;
        logic we = 0, other = 0, unstable = 0;
        logic [3:0]  sel = 0;
        logic [31:0] rdat = 0;
        string       p;
        p = $sformatf("v%0d", k);
        @(negedge clk);
        cur_d = t.d;
        cur_p = (t.d == 1) && !t.instr;
        instr = t.instr;
        addr  = t.a;
        wdata = t.wd;
        wstrb = t.ws;
        din   = t.din;
        v[t.d] = 1'b1;
        @(posedge clk);
        #1;
        v[t.d] = 1'b0;
        instr  = ~t.instr;
        addr   = ~t.a;
        wdata  = ~t.wd;
        wstrb  = ~t.ws;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c == 0) begin
                we  = we_a;
                sel = sel_a;
            end
            if (cyc_a) begin
                ncyc++;
                if (addr_a !== t.a || dout_a !== t.wd || sel_a !== sel) unstable = 1'b1;
            end
            if (stb_a) nstb++;
            if (cyc_o) other = 1'b1;
            ack  = (c == t.dly);
            wack = (c == t.xw);
            if (rdy_a) begin
                lat  = c + 1;
                rdat = rd_a;
                ack  = 1'b0;
                wack = 1'b0;
                break;
            end
        end
        ack  = 1'b0;
        wack = 1'b0;
        chk({p, " stb_cycles"}, nstb, t.nstb);
        chk({p, " cyc_cycles"}, ncyc, t.ncyc);
        chk({p, " we"}, {31'b0, we}, {31'b0, t.we});
        chk({p, " sel"}, {28'b0, sel}, {28'b0, t.sel});
        chk({p, " bus_fields_stable"}, {31'b0, unstable}, 32'd0);
        chk({p, " other_port_cyc"}, {31'b0, other}, 32'd0);
        chk({p, " ready_latency"}, lat, t.lat);
        chk({p, " rdata"}, rdat, t.rdata);
        chk({p, " bus_err"}, {31'b0, berr_a}, {31'b0, t.berr});
        chk({p, " timeout_cnt"}, {24'b0, tc_a}, {24'b0, t.tc});
        @(negedge clk);
        chk({p, " ready_one_cycle"}, {31'b0, rdy_a}, 32'd0);
    endtask
    vec_t tv[11];
    vec_t tail;
    initial begin
        tv[0]  = '{0, 1'b0, 32'h100,  32'h11111111, 4'h0, 3,  1,  32'hDEADBEEF, 4,  4,  1'b0, 4'hF, 5,  32'hDEADBEEF, 1'b0, 8'd0};
        tv[1]  = '{0, 1'b0, 32'h203,  32'hAA000000, 4'h8, 0,  -1, 32'h12345678, 1,  1,  1'b1, 4'h8, 2,  32'hDEADBEEF, 1'b0, 8'd0};
        tv[2]  = '{0, 1'b0, 32'h400,  32'hCAFEF00D, 4'hF, 1,  -1, 32'h00000000, 2,  2,  1'b1, 4'hF, 3,  32'hDEADBEEF, 1'b0, 8'd0};
        tv[3]  = '{0, 1'b1, 32'h8,    32'h00000000, 4'h0, 0,  -1, 32'h0BADC0DE, 1,  1,  1'b0, 4'hF, 2,  32'h0BADC0DE, 1'b0, 8'd0};
        tv[4]  = '{1, 1'b1, 32'h1000, 32'h00000000, 4'h0, 5,  2,  32'h13579BDF, 1,  6,  1'b0, 4'hF, 7,  32'h13579BDF, 1'b0, 8'd0};
        tv[5]  = '{1, 1'b0, 32'h2004, 32'h00000000, 4'h0, 2,  0,  32'h2468ACE0, 1,  3,  1'b0, 4'hF, 4,  32'h2468ACE0, 1'b0, 8'd0};
        tv[6]  = '{1, 1'b0, 32'h3000, 32'h0000BEEF, 4'h3, 0,  -1, 32'h99999999, 1,  1,  1'b1, 4'h3, 2,  32'h2468ACE0, 1'b0, 8'd0};
        tv[7]  = '{0, 1'b0, 32'h500,  32'h00000000, 4'h0, 15, -1, 32'h55AA55AA, 16, 16, 1'b0, 4'hF, 17, 32'h55AA55AA, 1'b0, 8'd0};
        tv[8]  = '{0, 1'b0, 32'h600,  32'h00000000, 4'h0, -1, -1, 32'h00000000, 16, 16, 1'b0, 4'hF, 17, 32'hFFFFFFFF, 1'b1, 8'd1};
        tv[9]  = '{0, 1'b0, 32'h700,  32'h00000000, 4'h0, 0,  -1, 32'h00000077, 1,  1,  1'b0, 4'hF, 2,  32'h00000077, 1'b1, 8'd1};
        tv[10] = '{0, 1'b0, 32'h800,  32'h00000001, 4'h1, -1, -1, 32'h00000000, 16, 16, 1'b1, 4'h1, 17, 32'hFFFFFFFF, 1'b1, 8'd2};
        tail   = '{0, 1'b0, 32'hB00,  32'h00000000, 4'h0, 2,  -1, 32'hFEED0001, 3,  3,  1'b0, 4'hF, 4,  32'hFEED0001, 1'b0, 8'd0};
        rst = 1'b1; v[0] = 1'b0; v[1] = 1'b0; instr = 1'b0; addr = '0; wdata = '0; wstrb = '0;
        din = '0; ack = 1'b0; wack = 1'b0; cur_d = 0; cur_p = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("reset_core_u%0d", i), {26'b0, cc[i], cs[i], cw[i], csel[i]} | cadr[i] | cdo[i], 32'd0);
            chk($sformatf("reset_dm_u%0d", i), {26'b0, dc[i], ds[i], dw[i], dsel[i]} | dadr[i] | ddo[i], 32'd0);
            chk($sformatf("reset_native_u%0d", i), {22'b0, rdy[i], berr[i], tcnt[i]} | rd[i], 32'd0);
        end
        rst = 1'b0;
        for (int k = 0; k < 11; k++) run_vec(k, tv[k]);
        // valid held high: ignored in DONE, re-accepted from IDLE
        @(negedge clk);
        cur_d = 0; cur_p = 1'b0; instr = 1'b0; addr = 32'h900; wstrb = 4'h0; din = 32'h42;
        v[0] = 1'b1; ack = 1'b1;
        @(negedge clk);
        chk("hold c0 cyc", {31'b0, cyc_a}, 32'd1);
        @(negedge clk);
        ack = 1'b0;
        chk("hold c1 ready", {31'b0, rdy_a}, 32'd1);
        chk("hold c1 rdata", rd_a, 32'h42);
        chk("hold c1 cyc", {31'b0, cyc_a}, 32'd0);
        @(negedge clk);
        chk("hold c2 cyc", {31'b0, cyc_a}, 32'd0);
        chk("hold c2 ready", {31'b0, rdy_a}, 32'd0);
        @(negedge clk);
        chk("hold c3 cyc", {31'b0, cyc_a}, 32'd1);
        v[0] = 1'b0; ack = 1'b1; din = 32'h43;
        @(negedge clk);
        ack = 1'b0;
        chk("hold c4 ready", {31'b0, rdy_a}, 32'd1);
        chk("hold c4 rdata", rd_a, 32'h43);
        // reset while waiting for ack
        @(negedge clk);
        addr = 32'hA00; wstrb = 4'h0; v[0] = 1'b1;
        @(posedge clk);
        #1 v[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("rstwait pre cyc", {31'b0, cyc_a}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ack = 1'b1;
        chk("rstwait cyc_stb_we", {29'b0, cyc_a, stb_a, we_a}, 32'd0);
        chk("rstwait sel_addr_dout", {28'b0, sel_a} | addr_a | dout_a, 32'd0);
        chk("rstwait rdata", rd_a, 32'd0);
        chk("rstwait err_cnt", {23'b0, berr_a, tc_a}, 32'd0);
        begin
            int nr = 0;
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                ack = 1'b0;
                if (rdy_a || cyc_a) nr++;
            end
            chk("rstwait no_ready", nr, 32'd0);
        end
        run_vec(11, tail);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
